// File: rtl/regfile_pkg.sv
// Shared types, default sizes and helpers for the register file slice.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_NUM_REGS = 32;

  // Bulk-clear engine states
  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  // True when addr names the hardwired-zero register
  function automatic logic is_zero_reg(input int unsigned addr, input int unsigned zero_reg);
    return (zero_reg != 0) && (addr == 0);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr_active,
  input  logic [ADDR_W-1:0]   clr_idx,
  input  logic                rsv_en,
  input  logic [ADDR_W-1:0]   rsv_addr,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] busy_d;

  // Clear engine owns the vector while active; otherwise a reservation beats a retire
  always_comb begin
    busy_d = busy;
    if (clr_active) begin
      busy_d[clr_idx] = 1'b0;
    end else begin
      if (wr_en) busy_d[wr_addr] = 1'b0;
      if (rsv_en && !is_zero_reg(32'(rsv_addr), ZERO_REG)) busy_d[rsv_addr] = 1'b1;
    end
  end

  // Busy vector register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= busy_d;
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write bypass, scoreboard and sequenced bulk clear.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0][DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]             rd_busy,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          rsv_en,
  input  logic [ADDR_W-1:0]             rsv_addr,
  input  logic                          clr_req,
  output logic                          clr_busy
);

  rf_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                clearing;
  logic                wr_ok;
  logic [NUM_RD-1:0]   hit;
  logic [NUM_REGS-1:0] busy;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  assign clearing = (state_q == RF_CLEAR);
  // A write lands (and bypasses) only outside a clear and not to the zero register
  assign wr_ok = wr_en && !clearing && !is_zero_reg(32'(wr_addr), ZERO_REG);

  // Clear engine next state: sweep idx from 0 to NUM_REGS-1, one register per cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      RF_IDLE: begin
        if (clr_req) begin
          state_d = RF_CLEAR;
          idx_d   = '0;
        end
      end
      RF_CLEAR: begin
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == ADDR_W'(NUM_REGS - 1)) state_d = RF_IDLE;
      end
      default: state_d = RF_IDLE;
    endcase
  end

  // Clear engine state, index and registered busy flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RF_IDLE;
      idx_q    <= '0;
      clr_busy <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      clr_busy <= (state_d == RF_CLEAR);
    end
  end

  // Data array: clear sweep has priority, writes dropped while it runs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (clearing) begin
      regs[idx_q] <= '0;
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .clr_active (clearing),
    .clr_idx    (idx_q),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .busy       (busy)
  );

  // Read muxes with same-cycle writeback bypass; a retiring write reads as not busy
  always_comb begin
    hit     = '0;
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      hit[p] = wr_ok && (wr_addr == rd_addr[p]);
      if (is_zero_reg(32'(rd_addr[p]), ZERO_REG)) rd_data[p] = '0;
      else if (hit[p])                           rd_data[p] = wr_data;
      else                                       rd_data[p] = regs[rd_addr[p]];
      rd_busy[p] = busy[rd_addr[p]] & ~hit[p];
    end
  end

endmodule
